// File: rtl/mem_if.sv
// mem_if: single-outstanding load/store stage between the core memory port
// and a word-addressed valid/ready bus, with lane alignment and extension.
module mem_if #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        misaligned_o,
    output logic        timeout_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        to_q;
    logic [31:0] cnt_q;

    logic        fault;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;
    logic        to_hit;
    logic        capture;
    logic        accept;
    logic        abort;

    // request decode: alignment check, lane enables, lane replication
    always_comb begin
        fault = 1'b0;
        be_n  = 4'b0000;
        wd_n  = wdata_i;
        unique case (size_i)
            2'd0: begin
                be_n = 4'b0001 << addr_i[1:0];
                wd_n = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                fault = addr_i[0];
                be_n  = 4'b0011 << addr_i[1:0];
                wd_n  = {2{wdata_i[15:0]}};
            end
            2'd2: begin
                fault = |addr_i[1:0];
                be_n  = 4'b1111;
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    always_comb begin
        byte_sel = bus_rdata_i[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_sel = bus_rdata_i[7:0];
            2'd1: byte_sel = bus_rdata_i[15:8];
            2'd2: byte_sel = bus_rdata_i[23:16];
            2'd3: byte_sel = bus_rdata_i[31:24];
            default: byte_sel = bus_rdata_i[7:0];
        endcase
        half_sel = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    end

    always_comb begin
        ext = bus_rdata_i;
        unique case (size_q)
            2'd0: ext = uns_q ? {24'd0, byte_sel}
                              : {{24{byte_sel[7]}}, byte_sel};
            2'd1: ext = uns_q ? {16'd0, half_sel}
                              : {{16{half_sel[15]}}, half_sel};
            default: ext = bus_rdata_i;
        endcase
    end

    assign to_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = fault ? RESP : BUS;
                end
            end
            BUS: begin
                // ready wins over an abort landing in the same cycle
                if (bus_ready_i) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end else if (to_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else if (capture) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= {addr_i[31:2], 2'b00} | {30'd0, addr_i[1:0]};
            be_q    <= fault ? 4'd0 : be_n;
            wdata_q <= wd_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            if (capture) begin
                cnt_q <= 32'd0;
                mis_q <= fault;
                to_q  <= 1'b0;
                if (fault) begin
                    rdata_q <= 32'd0;
                end
            end
            if (accept) begin
                rdata_q <= we_q ? 32'd0 : ext;
                cnt_q   <= 32'd0;
            end else if (abort) begin
                rdata_q <= 32'd0;
                to_q    <= 1'b1;
                cnt_q   <= 32'd0;
            end else if (state_q == BUS) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (state_q == RESP) begin
                mis_q <= 1'b0;
                to_q  <= 1'b0;
            end
        end
    end

    assign rdata_o      = rdata_q;
    assign done_o       = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign misaligned_o = mis_q;
    assign timeout_o    = to_q;
    assign bus_valid_o  = (state_q == BUS);
    assign bus_we_o     = bus_valid_o & we_q;
    assign bus_be_o     = bus_valid_o ? be_q : 4'd0;
    assign bus_addr_o   = {addr_q[31:2], 2'b00};
    assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_if.sv
// tb_mem_if: drives directed and random load/store traffic into mem_if and
// compares every cycle against a byte-lane reference model.
module tb_mem_if;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        busy_o;
    logic        misaligned_o;
    logic        timeout_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_rd = 32'd0;

    mem_if #(.TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .misaligned_o (misaligned_o),
        .timeout_o    (timeout_o),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Called at a negedge in IDLE; returns at a negedge in the following IDLE.
    task automatic access(input logic we, input logic [1:0] sz,
                          input logic un, input logic [31:0] a,
                          input logic [31:0] wd, input int waits,
                          input logic [31:0] rword, input string nm);
        int nb, off, c;
        logic fault, tmo;
        logic [3:0] ebe;
        logic [31:0] ewd, eaddr, erd, mask;
        off = int'(a[1:0]);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        fault = (nb == 0) || ((off % nb) != 0);
        ebe = 4'd0;
        ewd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (!fault && i >= off && i < off + nb) ebe[i] = 1'b1;
            if (nb != 0) ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        eaddr = a - 32'(off);
        tmo = !fault && (waits >= TO);
        erd = 32'd0;
        if (!fault && !tmo && !we) begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            erd = (rword >> (8 * off)) & mask;
            if (!un && erd[8*nb-1]) erd = erd | ~mask;
        end

        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = un;
        addr_i = a; wdata_i = wd;
        @(negedge clk_i);
        req_i = 1'b0;
        if (!fault) begin
            c = 0;
            forever begin
                checks++;
                if ({bus_valid_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}
                    !== {1'b1, we, ebe, eaddr, ewd}) begin
                    errors++;
                    $display("FAIL %s bus c%0d got v%b w%b be%h a%h d%h exp v1 w%b be%h a%h d%h",
                             nm, c, bus_valid_o, bus_we_o, bus_be_o, bus_addr_o,
                             bus_wdata_o, we, ebe, eaddr, ewd);
                end
                checks++;
                if ({done_o, busy_o, rdata_o} !== {1'b0, 1'b1, prev_rd}) begin
                    errors++;
                    $display("FAIL %s busphase c%0d got done%b busy%b rd%h exp done0 busy1 rd%h",
                             nm, c, done_o, busy_o, rdata_o, prev_rd);
                end
                if (c == waits) begin
                    bus_ready_i = 1'b1;
                    bus_rdata_i = rword;
                end else begin
                    bus_ready_i = 1'b0;
                    bus_rdata_i = $urandom;
                end
                req_i = 1'($urandom);
                @(negedge clk_i);
                if (c == waits || c == TO - 1) break;
                c++;
            end
            bus_ready_i = 1'b0;
            req_i = 1'b0;
        end
        checks++;
        if ({done_o, busy_o, bus_valid_o, misaligned_o, timeout_o, rdata_o}
            !== {1'b1, 1'b1, 1'b0, fault, tmo, erd}) begin
            errors++;
            $display("FAIL %s resp got done%b busy%b v%b mis%b to%b rd%h exp done1 busy1 v0 mis%b to%b rd%h",
                     nm, done_o, busy_o, bus_valid_o, misaligned_o, timeout_o,
                     rdata_o, fault, tmo, erd);
        end
        @(negedge clk_i);
        checks++;
        if ({done_o, busy_o, bus_valid_o, misaligned_o, timeout_o, rdata_o}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, erd}) begin
            errors++;
            $display("FAIL %s idle got done%b busy%b v%b mis%b to%b rd%h exp all0 rd%h",
                     nm, done_o, busy_o, bus_valid_o, misaligned_o, timeout_o,
                     rdata_o, erd);
        end
        prev_rd = erd;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0;
        unsigned_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
        bus_ready_i = 1'b0; bus_rdata_i = 32'd0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({rdata_o, done_o, busy_o, misaligned_o, timeout_o, bus_valid_o,
             bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o} !== 104'd0) begin
            errors++;
            $display("FAIL reset_state got rd%h done%b busy%b v%b a%h be%h d%h exp all 0",
                     rdata_o, done_o, busy_o, bus_valid_o, bus_addr_o,
                     bus_be_o, bus_wdata_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        prev_rd = 32'd0;
    endtask

    task automatic test_directed();
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, "word_ld");
        access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF1234, "byte_ld_s");
        access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FF1234, "byte_ld_u");
        access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0, "half_st");
        access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, "mis_word");
        access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, "mis_size3");
        access(1'b0, 2'd1, 1'b0, 32'h302, 32'h0, 1, 32'h8001_7FFF, "half_ld_hi");
    endtask

    task automatic test_timeout();
        access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1000, 32'h0, "timeout");
        access(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, TO - 1, 32'h1234_5678, "last_ready");
    endtask

    task automatic test_async_reset();
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0;
        addr_i = 32'h500; wdata_i = 32'h0;
        @(negedge clk_i);
        req_i = 1'b0;
        bus_ready_i = 1'b0;
        @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if ({bus_valid_o, busy_o, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL async_rst got v%b busy%b done%b exp 000",
                     bus_valid_o, busy_o, done_o);
        end
        @(negedge clk_i);
        checks++;
        if ({done_o, rdata_o} !== 33'd0) begin
            errors++;
            $display("FAIL rst_nodone got done%b rd%h exp 0", done_o, rdata_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_release got done%b busy%b exp 00", done_o, busy_o);
        end
        prev_rd = 32'd0;
        access(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 0, 32'hCAFE_F00D, "post_rst");
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = int'($time);
        access(1'b0, 2'd0, 1'b1, 32'h601, 32'h0, 0, 32'h0000_AB00, "b2b_0");
        access(1'b1, 2'd2, 1'b0, 32'h604, 32'h1111_2222, 0, 32'h0, "b2b_1");
        checks++;
        if (int'($time) - t0 !== 60) begin
            errors++;
            $display("FAIL b2b_interval got %0d exp 60", int'($time) - t0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   int'($urandom_range(0, 5)), $urandom, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_if.md
# mem_if

Memory interface stage placed directly downstream of the core datapath's memory port. It accepts one load/store request at a time from the core and performs byte/half/word alignment, byte-enable generation and load sign/zero extension. It carries the access to a word-addressed external bus with a valid/ready handshake and wait states, and returns a registered result with a one-cycle completion pulse the control unit uses to leave its memory-wait state.

## Interface
- TIMEOUT, default 0: max cycles bus_valid_o may stay high without bus_ready_i before abort; 0 disables.
- clk_i  in  1  clock, rising-edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  1  core request strobe; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 byte, 1 half, 2 word, 3 illegal.
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- rdata_o  out  32  load result, registered, held until next done_o.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in every state but IDLE.
- misaligned_o  out  1  fault flag, valid with done_o.
- timeout_o  out  1  timeout flag, valid with done_o.
- bus_valid_o  out  1  bus request.
- bus_ready_i  in  1  bus accept; read data valid the same cycle.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  word address, addr_i with bits [1:0] cleared.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_rdata_i  in  32  read word.

## Operation
- States: IDLE, BUS, RESP.
- IDLE, req_i=1: capture we/size/unsigned/addr/wdata.
  - Fault case: size 3, half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with misaligned set. No bus cycle is issued.
  - Otherwise: go to BUS.
- BUS: bus_valid_o=1. Address, be, we and wdata are stable until accepted.
  - On bus_valid_o && bus_ready_i: latch the extracted load value (loads only) and go to RESP.
  - With TIMEOUT>0: a counter starts at 0 on entry and increments each cycle without ready. Reaching TIMEOUT-1 with no ready aborts to RESP with timeout set; bus_valid_o drops.
- RESP: done_o=1 for exactly one cycle, then IDLE. req_i is ignored in RESP and BUS.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Loads drive the same be.
- Store data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: unchanged.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - Extended to 32 bits per unsigned_i.
- rdata_o updates only on a successful load. Stores, faults and timeouts load 0.
- misaligned_o and timeout_o are cleared when leaving RESP.

## Timing
- Reset (asynchronous, any state): state IDLE.
  - All outputs 0, including bus_valid_o, which drops the same cycle reset asserts; counter 0.
  - An in-flight bus access is abandoned and no done_o is produced.
- Aligned access with immediate ready: req at edge 0 → bus_valid_o during cycle 1 → done_o during cycle 2. Latency is 2 cycles plus N wait cycles.
- Fault: req at edge 0 → done_o + misaligned_o during cycle 1.
- Timeout: bus_valid_o is high exactly TIMEOUT cycles, then done_o + timeout_o in the next cycle.
- Back-to-back: a new req_i is accepted in the cycle after done_o (IDLE). The minimum issue interval is 3 cycles.
- No combinational path from bus_ready_i or bus_rdata_i to any core-side output.

## Test plan
- Word load at 0x100, ready in first BUS cycle, bus_rdata 0xDEADBEEF → bus_addr 0x100, be 4'hF, done at cycle 2, rdata_o 0xDEADBEEF.
- Byte loads at 0x103 with bus_rdata 0x80FF1234: signed → rdata_o 0xFFFFFF80; unsigned → 0x00000080.
- Half store at 0x202, wdata 0x0000ABCD, ready after 3 wait cycles → bus_addr 0x200, be 4'b1100, bus_wdata 0xABCDABCD held 4 cycles; done once; rdata_o 0.
- Word load at 0x101 and size=3 at 0x100 → no bus_valid_o; done_o + misaligned_o one cycle after req.
- TIMEOUT=4, ready tied 0 → bus_valid_o high 4 cycles, then done_o + timeout_o; req_i pulses during BUS ignored.
- Assert reset_i low in the second BUS cycle → bus_valid_o, busy_o low immediately, no done_o; next request after release completes normally.
